seg_decoder_rx: RTL and testbench

- Receiving end of the seven-segment display interface: samples the 7 segment lines driven by the display encoder and recovers the 4-bit hex digit being shown.
- Synchronizes, filters for stability, decodes, flags illegal patterns, and hands each newly settled digit to a consumer over a valid/ready handshake.
- Sits in the self-check path: the encoder output is looped back so hardware confirms the digit shown matches the switches.

---
 rtl/seg_decoder_rx.sv | 183 ++++++++++++++++++
 tb/tb_seg_decoder_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decoder_rx.sv
// seg_decoder_rx: receiving end of the seven-segment loopback path.
// Synchronizes the segment lines, waits for a pattern to stay stable for
// STABLE_CYCLES samples, decodes it to a hex digit (flagging non-glyph
// patterns as illegal) and offers each newly settled result over valid/ready.
// Optional build macro SEGRX_ACTIVE_HIGH_EN: segment lines are active-high
// (glyph table inverted, blank/reset pattern becomes 7'h00).
module seg_decoder_rx #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       illegal,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_EMIT   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

`ifdef SEGRX_ACTIVE_HIGH_EN
    localparam logic [6:0] SEG_BLANK = 7'h00;
`else
    localparam logic [6:0] SEG_BLANK = 7'h7F;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Map a segment pattern to {illegal, digit}; non-glyph patterns give {1, 0}.
    function automatic logic [4:0] f_decode(input logic [6:0] i_pat);
        logic [6:0] w_low;
`ifdef SEGRX_ACTIVE_HIGH_EN
        w_low = ~i_pat;
`else
        w_low = i_pat;
`endif
        case (w_low)
            7'h40:   f_decode = {1'b0, 4'h0};
            7'h79:   f_decode = {1'b0, 4'h1};
            7'h24:   f_decode = {1'b0, 4'h2};
            7'h30:   f_decode = {1'b0, 4'h3};
            7'h19:   f_decode = {1'b0, 4'h4};
            7'h12:   f_decode = {1'b0, 4'h5};
            7'h02:   f_decode = {1'b0, 4'h6};
            7'h78:   f_decode = {1'b0, 4'h7};
            7'h00:   f_decode = {1'b0, 4'h8};
            7'h10:   f_decode = {1'b0, 4'h9};
            7'h08:   f_decode = {1'b0, 4'hA};
            7'h03:   f_decode = {1'b0, 4'hB};
            7'h46:   f_decode = {1'b0, 4'hC};
            7'h21:   f_decode = {1'b0, 4'hD};
            7'h06:   f_decode = {1'b0, 4'hE};
            7'h0E:   f_decode = {1'b0, 4'hF};
            default: f_decode = {1'b1, 4'h0};
        endcase
    endfunction

    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [6:0]       r_prev;
    logic [6:0]       r_settled;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_match;
    logic             w_latch;
    logic [4:0]       w_dec;
    logic [3:0]       r_digit;
    logic             r_illegal;
    logic             r_valid;
    logic             r_overrun;

    assign w_match = (r_sync2 == r_prev);
    assign w_dec   = f_decode(r_settled);

    assign digit     = r_digit;
    assign illegal   = r_illegal;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

    // Two-flop synchronizer plus one-cycle-old copy for the stability compare.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= SEG_BLANK;
            r_sync2 <= SEG_BLANK;
            r_prev  <= SEG_BLANK;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Stability counter: restarts on any change, saturates once settled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= CNT_ZERO;
        end else if (!w_match) begin
            r_cnt <= CNT_ZERO;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // State register and latch of the most recently settled pattern.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_SETTLE;
            r_settled <= SEG_BLANK;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_settled <= r_sync2;
            end else begin
                r_settled <= r_settled;
            end
        end
    end

    // Next-state logic: a change always restarts settling; a settled pattern
    // only emits when it differs from the previous settled one.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        if (!w_match) begin
            w_state_nxt = ST_SETTLE;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_cnt >= CNT_LAST) begin
                        if (r_sync2 != r_settled) begin
                            w_state_nxt = ST_EMIT;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_EMIT: w_state_nxt = ST_HOLD;
                ST_HOLD: w_state_nxt = ST_HOLD;
                default: w_state_nxt = ST_SETTLE;
            endcase
        end
    end

    // Result register and handshake; an emit overrides a pending accept and
    // flags overrun only when the previous result was not being taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_digit   <= 4'h0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_state == ST_EMIT) begin
            r_digit   <= w_dec[3:0];
            r_illegal <= w_dec[4];
            r_valid   <= 1'b1;
            if (r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: tb/tb_seg_decoder_rx.sv
// Testbench for seg_decoder_rx: directed table sweep, multi-cycle corner
// sequences, and randomized traffic checked every cycle against a
// run-length reference model. Works for both polarity builds.
module tb_seg_decoder_rx;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       illegal;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;

    always #5 clk = ~clk;

    seg_decoder_rx #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .digit     (digit),
        .illegal   (illegal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Active-low glyphs for 0..F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Convert an active-low pattern to the bus encoding of this build (and back).
    function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEGRX_ACTIVE_HIGH_EN
        enc = ~p;
`else
        enc = p;
`endif
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] bus);
        logic [6:0] lo;
        lo = enc(bus);
        ref_decode = {1'b1, 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == lo) ref_decode = {1'b0, 4'(i)};
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts identical consecutive samples; a run of S+1
    // samples of a new value becomes visible as a result 3 edges later.
    typedef struct { int due; logic [4:0] val; } pend_t;
    pend_t      pend[$];
    int         cyc = 0;
    logic [6:0] m_last;
    int         m_run;
    logic [6:0] m_settled;
    logic       m_valid, m_illegal, m_overrun;
    logic [3:0] m_digit;

    task automatic tick();
        logic [6:0] s;
        logic       r;
        logic       rd;
        s  = seg_in;
        r  = reset;
        rd = out_ready;
        @(posedge clk);
        cyc++;
        if (!r) begin
            pend.delete();
            m_last = enc(7'h7F); m_run = 1; m_settled = enc(7'h7F);
            m_valid = 1'b0; m_illegal = 1'b0; m_overrun = 1'b0; m_digit = 4'h0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (m_valid && !rd) m_overrun = 1'b1;
                {m_illegal, m_digit} = pend[0].val;
                m_valid = 1'b1;
                void'(pend.pop_front());
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
            if (s == m_last) m_run++;
            else begin m_last = s; m_run = 1; end
            if (m_run == S + 1 && s != m_settled) begin
                m_settled = s;
                pend.push_back('{cyc + 3, ref_decode(s)});
            end
        end
        #1;
        chk("model_valid", out_valid, m_valid);
        chk("model_overrun", overrun, m_overrun);
        chk("model_digit", digit, m_digit);
        chk("model_illegal", illegal, m_illegal);
    endtask

    // Run n cycles, counting accepted results and remembering the last one.
    task automatic run(input int n, output int acc, output logic [3:0] ldig, output logic lill);
        acc = 0; ldig = 4'h0; lill = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid && out_ready) begin
                acc++; ldig = digit; lill = illegal;
            end
        end
    endtask

    typedef struct { logic [6:0] pat; logic [3:0] dig; logic ill; } vec_t;
    vec_t vecs [18];

    initial begin
        int         k;
        bit         got;
        int         acc;
        logic [3:0] ld;
        logic       li;
        logic [6:0] cur;
        int         hold;

        vecs[0] = '{7'h7F, 4'h0, 1'b1};
        vecs[1] = '{7'h55, 4'h0, 1'b1};
        for (int i = 0; i < 16; i++) vecs[i + 2] = '{glyph[i], 4'(i), 1'b0};

        // Reset held with digit 0 on the bus.
        reset = 1'b0; seg_in = enc(7'h40); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_overrun", overrun, 1'b0);
        end
        reset = 1'b1;
        k = 0; got = 0;
        while (k < 40 && !got) begin
            tick(); k++;
            if (out_valid) got = 1;
        end
        chk("latency", k - 1, 19);
        chk("first_digit", digit, 4'h0);
        chk("first_illegal", illegal, 1'b0);

        // Table sweep: blank, junk, then all 16 glyphs.
        out_ready = 1'b1;
        for (int v = 0; v < 18; v++) begin
            seg_in = enc(vecs[v].pat);
            run(24, acc, ld, li);
            chk("sweep_count", acc, 1);
            chk("sweep_digit", ld, vecs[v].dig);
            chk("sweep_illegal", li, vecs[v].ill);
        end

        // Short glitch away and back: single emit of 2.
        seg_in = enc(7'h24);
        run(24, acc, ld, li);
        chk("glitch_first_count", acc, 1);
        chk("glitch_first_digit", ld, 4'h2);
        seg_in = enc(7'h79);
        run(5, acc, ld, li);
        k = acc;
        seg_in = enc(7'h24);
        run(30, acc, ld, li);
        chk("glitch_no_emit", k + acc, 0);

        // Overrun: two results with no consumer.
        out_ready = 1'b0;
        seg_in = enc(7'h30);
        run(24, acc, ld, li);
        seg_in = enc(7'h78);
        run(24, acc, ld, li);
        chk("ovr_valid", out_valid, 1'b1);
        chk("ovr_digit", digit, 4'h7);
        chk("ovr_flag", overrun, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("ovr_accept_valid", out_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);

        // Reset mid-settle.
        seg_in = enc(7'h40);
        run(8, acc, ld, li);
        reset = 1'b0;
        tick();
        chk("rst_settle_valid", out_valid, 1'b0);
        chk("rst_settle_overrun", overrun, 1'b0);
        chk("rst_settle_digit", digit, 4'h0);
        chk("rst_settle_illegal", illegal, 1'b0);
        reset = 1'b1; out_ready = 1'b0;
        k = 0; got = 0;
        while (k < 40 && !got) begin
            tick(); k++;
            if (out_valid) got = 1;
        end
        chk("post_rst_emit", got, 1'b1);
        // Reset mid-handshake.
        reset = 1'b0;
        tick();
        chk("rst_hs_valid", out_valid, 1'b0);
        chk("rst_hs_digit", digit, 4'h0);
        chk("rst_hs_overrun", overrun, 1'b0);
        reset = 1'b1; out_ready = 1'b1;
        run(24, acc, ld, li);

        // Randomized traffic against the model.
        cur = enc(7'h40);
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 9))
                7:       cur = enc(7'h7F);
                8:       cur = 7'($urandom);
                9:       cur = cur;
                default: cur = enc(glyph[$urandom_range(0, 15)]);
            endcase
            seg_in = cur;
            hold = $urandom_range(1, 30);
            for (int t = 0; t < hold; t++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                reset = ($urandom_range(0, 199) != 0);
                tick();
            end
            reset = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
